// File: rtl/m1_phase_decoder_if.sv
// Handshake and counter bus between the M1 counter bank / calibration
// controller (master) and the phase decoder (slave).
interface m1_phase_decoder_if #(
    parameter int CW = 8
);
    logic          meas_start;
    logic [CW-1:0] start_cnt_p;
    logic [CW-1:0] start_cnt_n;
    logic [CW-1:0] stop_cnt_p;
    logic [CW-1:0] stop_cnt_n;
    logic          result_ack;
    logic [CW:0]   phase_half;
    logic          result_valid;
    logic          meas_err;
    logic          busy;

    modport master (
        output meas_start, start_cnt_p, start_cnt_n, stop_cnt_p, stop_cnt_n, result_ack,
        input  phase_half, result_valid, meas_err, busy
    );

    modport slave (
        input  meas_start, start_cnt_p, start_cnt_n, stop_cnt_p, stop_cnt_n, result_ack,
        output phase_half, result_valid, meas_err, busy
    );
endinterface

// File: rtl/m1_phase_decoder.sv
// Turns the four M1 delay-line edge counters into one start-to-stop phase
// offset (in half-cycles of L_start_Dclk) per request, with a result handshake.
module m1_phase_decoder #(
    parameter int Dc_length    = 13,
    parameter int DE_bits      = 6,
    parameter int Count_length = Dc_length - DE_bits,
    parameter int SETTLE_CYC   = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic                L_start_Dclk,
    input  logic                reset_m1,
    m1_phase_decoder_if.slave   bus
);
    localparam int CW = Count_length + 1;
    localparam int PW = Count_length + 2;
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    localparam int RW = $clog2(MAX_RETRY) + 1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CHECK, COMPUTE, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] s_start_p_q, s_start_p_d;
    logic [CW-1:0] s_start_n_q, s_start_n_d;
    logic [CW-1:0] s_stop_p_q, s_stop_p_d;
    logic [CW-1:0] s_stop_n_q, s_stop_n_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [PW-1:0] sum_start, sum_stop;

    // Both sums and the difference live in PW bits so counter wrap cancels out.
    assign sum_start = PW'(s_start_p_q) + PW'(s_start_n_q);
    assign sum_stop  = PW'(s_stop_p_q) + PW'(s_stop_n_q);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        retry_d     = retry_q;
        s_start_p_d = s_start_p_q;
        s_start_n_d = s_start_n_q;
        s_stop_p_d  = s_stop_p_q;
        s_stop_n_d  = s_stop_n_q;
        phase_d     = phase_q;
        valid_d     = valid_q;
        err_d       = err_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.meas_start) begin
                    settle_d = SW'(SETTLE_CYC - 1);
                    retry_d  = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) state_d = SAMPLE;
                else                settle_d = settle_q - SW'(1);
            end
            SAMPLE: begin
                s_start_p_d = bus.start_cnt_p;
                s_start_n_d = bus.start_cnt_n;
                s_stop_p_d  = bus.stop_cnt_p;
                s_stop_n_d  = bus.stop_cnt_n;
                state_d     = CHECK;
            end
            CHECK: begin
                // Stop counters run asynchronously; accept only if they held still.
                if (bus.stop_cnt_p == s_stop_p_q && bus.stop_cnt_n == s_stop_n_q) begin
                    state_d = COMPUTE;
                end else if (retry_q + RW'(1) == RW'(MAX_RETRY)) begin
                    err_d   = 1'b1;
                    phase_d = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = SAMPLE;
                end
            end
            COMPUTE: begin
                phase_d = sum_start - sum_stop;
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.result_ack) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge L_start_Dclk or posedge reset_m1) begin
        if (reset_m1) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            retry_q     <= '0;
            s_start_p_q <= '0;
            s_start_n_q <= '0;
            s_stop_p_q  <= '0;
            s_stop_n_q  <= '0;
            phase_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            retry_q     <= retry_d;
            s_start_p_q <= s_start_p_d;
            s_start_n_q <= s_start_n_d;
            s_stop_p_q  <= s_stop_p_d;
            s_stop_n_q  <= s_stop_n_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.phase_half   = phase_q;
    assign bus.result_valid = valid_q;
    assign bus.meas_err     = err_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/m1_phase_decoder.md
# m1_phase_decoder

- Consumes the four M1 delay-line edge counters: start/stop, each counted on posedge and negedge.
- Produces one calibrated phase measurement per request: the start-to-stop offset in half-cycles of `L_start_Dclk`.
- Runs a request/settle/stable-sample/compute/handshake FSM in the `L_start_Dclk` domain.
- Sits between the M1 counter bank and the DPWM calibration controller.
- It is held in reset whenever the counters are, so every measurement starts from a common zero point.

## Interface
Parameters:
- `Dc_length`, 13, duty-command width.
- `DE_bits`, 6, delay-element select width.
- `Count_length`, `Dc_length-DE_bits` (7); counter inputs are `Count_length+1` bits wide.
- `SETTLE_CYC`, 4, number of `L_start_Dclk` cycles to wait before sampling; must be ≥1.
- `MAX_RETRY`, 3, number of unstable samples tolerated before error; must be ≥1.

Ports:
- `L_start_Dclk`, in, 1: clock (rising edge).
- `reset_m1`, in, 1: reset, asynchronous, active-high.
- `meas_start`, in, 1: single-cycle measurement request.
- `start_cnt_p`, in, `Count_length+1`: start counter, posedge count.
- `start_cnt_n`, in, `Count_length+1`: start counter, negedge count.
- `stop_cnt_p`, in, `Count_length+1`: stop counter, posedge count (asynchronous domain).
- `stop_cnt_n`, in, `Count_length+1`: stop counter, negedge count (asynchronous domain).
- `result_ack`, in, 1: consumer accepts the result.
- `phase_half`, out, `Count_length+2`: measured offset in half-cycles.
- `result_valid`, out, 1: result held and available.
- `meas_err`, out, 1: stop counters never stabilised.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset value of all outputs and internal registers is 0; state is IDLE.
- IDLE:
  - On `meas_start`=1: load the settle counter with `SETTLE_CYC-1`, clear the retry counter, clear `meas_err`, go to SETTLE.
- SETTLE:
  - Decrement the settle counter each cycle; when it reaches 0, go to SAMPLE.
- SAMPLE:
  - Register all four counter inputs into snapshot `s_*`; go to CHECK.
- CHECK:
  - Compare the live `stop_cnt_p`/`stop_cnt_n` against the snapshot.
  - Both equal: go to COMPUTE.
  - Otherwise, if retry+1 == `MAX_RETRY`: set `meas_err`=1, set `phase_half`=0, go to DONE.
  - Otherwise: increment retry and return to SAMPLE.
- COMPUTE:
  - `phase_half` ← (`s_start_p`+`s_start_n`) − (`s_stop_p`+`s_stop_n`).
  - Each sum is `Count_length+2` bits; the subtraction is taken modulo 2^(`Count_length+2`), so counter wrap is absorbed.
  - Go to DONE.
- DONE:
  - `result_valid`=1; `phase_half` and `meas_err` are stable.
  - On `result_ack`=1: go to IDLE and drop `result_valid`.
  - `phase_half` and `meas_err` keep their values until the next request leaves IDLE.
- `meas_start` outside IDLE is ignored. This includes DONE, even when it coincides with `result_ack`.
- `result_ack` outside DONE is ignored.
- Only the stop pair is stability-checked. The start counters share this clock domain and are taken from the SAMPLE snapshot.

## Timing
- Edge numbering: edge 0 is the rising edge that samples `meas_start`=1. With S=`SETTLE_CYC`:
  - SETTLE occupies edges 1..S.
  - SAMPLE at edge S+1.
  - CHECK at edge S+2.
  - COMPUTE at edge S+3.
  - `result_valid` is high after edge S+3 (edge 7 with defaults).
- Each failed CHECK adds 2 edges.
- Error outcome: `result_valid` and `meas_err` are high after edge S+2·`MAX_RETRY` (edge 10 with defaults).
- `busy` rises after edge 0 and falls after the edge that samples `result_ack` in DONE.
- `reset_m1` asserted in any state immediately clears all outputs and returns the FSM to IDLE, independent of the clock; any in-flight measurement is aborted.
- Deassertion of `reset_m1` must be synchronised to `L_start_Dclk` by the driver (outside this block).

## Test plan
- Reset: assert `reset_m1` mid-SETTLE -> all outputs 0 at once; after release, `meas_start` runs a full measurement normally.
- Clean measurement: inputs start p/n=20/20, stop p/n=15/14, held constant; pulse `meas_start` -> `result_valid` after edge 7, `phase_half`=11, `meas_err`=0; `result_ack` -> `busy`=0 next edge.
- Wrap-around: inputs start p/n=2/1, stop p/n=255/255 -> `phase_half`=(3−510) mod 512=5.
- Unstable then stable: `stop_cnt_p` changes between SAMPLE and CHECK for the first two attempts only -> `result_valid` after edge 11, `meas_err`=0, correct `phase_half`.
- Never stable: `stop_cnt_n` toggles every cycle -> `result_valid`=1 and `meas_err`=1 after edge 10, `phase_half`=0; the next clean request clears `meas_err`.
- Handshake robustness:
  - `meas_start` pulsed during SETTLE and during DONE -> ignored.
  - `result_ack` held low for 20 cycles -> `result_valid` and `phase_half` hold.
  - `result_ack` in IDLE -> no effect.
